comparador_serial_der_izq: RTL and testbench
============================================

COMPARADOR_SERIAL_DER_IZQ -- requirements
Module: comparador_serial_der_izq

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning word width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, begins a new comparison.
REQ-005 The block SHALL have port bit_valid, input, 1, qualifies A_in/B_in this cycle.
REQ-006 The block SHALL have port A_in, input, 1, current bit of word A, LSB first.
REQ-007 The block SHALL have port B_in, input, 1, current bit of word B, LSB first.
REQ-008 The block SHALL have port busy, output, 1, high while the block is receiving bits.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port Zout, output, 1, result A <= B, registered.
REQ-011 The block SHALL have port iguales, output, 1, result A == B, registered.

Function
REQ-012 The block SHALL compare two N-bit words streamed serially right to left (bit 0 first), one bit pair per accepted cycle.
REQ-013 The FSM SHALL have two control states: IDLE, RECIBIENDO.
REQ-014 The relation register SHALL use encoding a=01 (equal so far), b=10 (A>B so far), c=11 (A<B so far).
REQ-015 In RECIBIENDO, with bit_valid=1: A_in==B_in keeps the relation; A_in=1,B_in=0 sets b; A_in=0,B_in=1 sets c. A higher bit always overrides lower bits.
REQ-016 In RECIBIENDO, a cycle with bit_valid=0 SHALL hold the relation and the bit counter; gaps of any length are legal.
REQ-017 start=1 in IDLE SHALL set relation=a, counter=0, busy=1, and enter RECIBIENDO on the next edge.
REQ-018 Bits SHALL NOT be sampled in the start cycle; bit 0 is the first bit_valid cycle after start.
REQ-019 start=1 while in RECIBIENDO SHALL abort the current word and restart as in REQ-017; done is not pulsed for the aborted word.
REQ-020 bit_valid=1 in IDLE SHALL be ignored.
REQ-021 The bit counter SHALL be ceil(log2(N+1)) bits wide and count accepted bits 0..N-1 with no wrap-around.
REQ-022 On the edge accepting bit N-1, the block SHALL return to IDLE, clear busy, load Zout=1 if the final relation is a or c and 0 if b, load iguales=1 only if it is a, and assert done for exactly the following cycle.
REQ-023 Latency SHALL be one cycle from the accepting edge of bit N-1 to done/Zout valid.
REQ-024 Zout and iguales SHALL hold their values until the next completed word; start alone does not clear them.
REQ-025 start=1 in the same cycle done is high SHALL be accepted normally.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, relation=a, counter=0, busy=0, done=0, Zout=0, iguales=0, independent of clk.
REQ-027 Reset asserted mid-word SHALL discard the partial comparison; no done pulse follows reset release.

Structure
REQ-028 The state encodings (a, b, c, IDLE, RECIBIENDO) and default N SHALL live in a shared include/package used by this block and the iterative-cell modules.
REQ-029 The next-relation logic SHALL be a combinational sub-module celda_der_izq (inputs: relation, A_in, B_in; output: next relation), reusable as one cell of a right-to-left iterative network.

Verification
REQ-030 N=4, A=0101, B=0101 streamed back-to-back after start -> done one cycle after 4th bit, Zout=1, iguales=1.
REQ-031 N=4, A=1000, B=0111 (lower bits favour B, MSB favours A) -> Zout=0, iguales=0.
REQ-032 N=4, A=0011, B=0100, bit_valid low for 3 cycles between bits 1 and 2 -> Zout=1, iguales=0, done exactly once.
REQ-033 N=4, start, 2 bits, start again, then A=1111/B=1110 -> one done only, Zout=0.
REQ-034 Reset pulse between bits 2 and 3, no further stimulus -> busy=0, done never asserted, Zout=0, iguales=0.
REQ-035 N=8, A=0xFF, B=0xFF, then a new start in the done cycle with A=0x00/B=0x01 -> first done Zout=1/iguales=1, second done Zout=1/iguales=0.

Source files
------------

// File: rtl/comparador_serial_der_izq_pkg.sv
// Shared encodings for the right-to-left serial comparator and its iterative cell.
// The relation codes double as the inter-cell signal of an iterative network.
package comparador_serial_der_izq_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    REL_A = 2'b01,
    REL_B = 2'b10,
    REL_C = 2'b11
  } rel_t;

  typedef enum logic {
    IDLE       = 1'b0,
    RECIBIENDO = 1'b1
  } state_t;

  // A <= B holds unless A is strictly greater.
  function automatic logic rel_a_le_b(input rel_t r);
    return (r != REL_B);
  endfunction

endpackage

// File: rtl/comparador_serial_der_izq_celda.sv
// One cell of a right-to-left comparator network: a differing bit pair overrides
// whatever the lower-order bits decided, an equal pair passes the relation through.
module celda_der_izq
  import comparador_serial_der_izq_pkg::*;
(
  input  rel_t rel_i,
  input  logic A_in,
  input  logic B_in,
  output rel_t rel_o
);

  always_comb begin
    rel_o = rel_i;
    if (A_in && !B_in) begin
      rel_o = REL_B;
    end else if (!A_in && B_in) begin
      rel_o = REL_C;
    end
  end

endmodule

// File: rtl/comparador_serial_der_izq.sv
// Serial N-bit comparator, LSB first; reports A <= B and A == B one cycle after
// the last bit is accepted.
module comparador_serial_der_izq
  import comparador_serial_der_izq_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_valid,
  input  logic A_in,
  input  logic B_in,
  output logic busy,
  output logic done,
  output logic Zout,
  output logic iguales
);

  localparam int CW = $clog2(N + 1);

  state_t        state_q;
  rel_t          rel_q;
  rel_t          rel_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          zout_q;
  logic          iguales_q;

  celda_der_izq u_celda (
    .rel_i (rel_q),
    .A_in  (A_in),
    .B_in  (B_in),
    .rel_o (rel_d)
  );

  // start has priority in both states so that it also aborts a word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rel_q     <= REL_A;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zout_q    <= 1'b0;
      iguales_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= RECIBIENDO;
        rel_q   <= REL_A;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RECIBIENDO: begin
            if (bit_valid) begin
              rel_q <= rel_d;
              if (cnt_q == CW'(N - 1)) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                zout_q    <= rel_a_le_b(rel_d);
                iguales_q <= (rel_d == REL_A);
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Zout    = zout_q;
  assign iguales = iguales_q;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Drives an N=4 and an N=8 comparator with the same serial stream and checks every
// cycle against an integer model that rebuilds A and B and compares them directly.
module tb_comparador_serial_der_izq;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic bitValid;
  logic aIn;
  logic bIn;

  logic busy4, done4, zout4, iguales4;
  logic busy8, done8, zout8, iguales8;

  int checks   = 0;
  int failures = 0;
  int doneCount4;

  int width [2] = '{4, 8};
  int mBusy [2];
  int mCnt  [2];
  longint mA [2];
  longint mB [2];
  int mDone [2];
  int mZ    [2];
  int mEq   [2];

  always #5 clk = ~clk;

  comparador_serial_der_izq #(.N(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_valid (bitValid),
    .A_in      (aIn),
    .B_in      (bIn),
    .busy      (busy4),
    .done      (done4),
    .Zout      (zout4),
    .iguales   (iguales4)
  );

  comparador_serial_der_izq #(.N(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_valid (bitValid),
    .A_in      (aIn),
    .B_in      (bIn),
    .busy      (busy8),
    .done      (done8),
    .Zout      (zout8),
    .iguales   (iguales8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mBusy[k] = 0; mCnt[k] = 0; mA[k] = 0; mB[k] = 0;
      mDone[k] = 0; mZ[k] = 0; mEq[k] = 0;
    end
  endtask

  // Behaviour at a rising edge: collect bits into integers and compare once full.
  task automatic modelEdge();
    for (int k = 0; k < 2; k++) begin
      mDone[k] = 0;
      if (reset) begin
        mBusy[k] = 0; mCnt[k] = 0; mZ[k] = 0; mEq[k] = 0;
      end else if (start) begin
        mBusy[k] = 1; mCnt[k] = 0; mA[k] = 0; mB[k] = 0;
      end else if (mBusy[k] != 0 && bitValid) begin
        if (aIn) mA[k] = mA[k] + (longint'(1) << mCnt[k]);
        if (bIn) mB[k] = mB[k] + (longint'(1) << mCnt[k]);
        mCnt[k]++;
        if (mCnt[k] == width[k]) begin
          mBusy[k] = 0;
          mDone[k] = 1;
          mZ[k]    = (mA[k] <= mB[k]) ? 1 : 0;
          mEq[k]   = (mA[k] == mB[k]) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("busy4",    32'(busy4),    32'(mBusy[0]));
    checkOutput("done4",    32'(done4),    32'(mDone[0]));
    checkOutput("zout4",    32'(zout4),    32'(mZ[0]));
    checkOutput("iguales4", 32'(iguales4), 32'(mEq[0]));
    checkOutput("busy8",    32'(busy8),    32'(mBusy[1]));
    checkOutput("done8",    32'(done8),    32'(mDone[1]));
    checkOutput("zout8",    32'(zout8),    32'(mZ[1]));
    checkOutput("iguales8", 32'(iguales8), 32'(mEq[1]));
  endtask

  // Sets inputs just after an edge, lets the next edge take them, then checks.
  task automatic applyStimulus(input logic st, input logic bv, input logic a, input logic b);
    start = st; bitValid = bv; aIn = a; bIn = b;
    @(posedge clk);
    modelEdge();
    #1;
    if (done4) doneCount4++;
    checkAll();
  endtask

  task automatic streamBits(input logic [7:0] a, input logic [7:0] b, input int n,
                            input int gapAfter, input int gapLen);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, a[i], b[i]);
      if (i == gapAfter) begin
        for (int g = 0; g < gapLen; g++)
          applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Reset is raised between edges and checked before any edge arrives.
  task automatic applyReset();
    reset = 1'b1;
    #2;
    modelReset();
    checkAll();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bitValid = 1'b0; aIn = 1'b0; bIn = 1'b0;
    doneCount4 = 0;
    #2;
    modelReset();
    checkAll();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idleCycles(3);

    // Equal words back-to-back.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    streamBits(8'h05, 8'h05, 4, -1, 0);
    checkOutput("r30_done", 32'(done4), 32'd1);
    checkOutput("r30_zout", 32'(zout4), 32'd1);
    checkOutput("r30_eq",   32'(iguales4), 32'd1);
    idleCycles(2);

    // MSB overrides the lower bits.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    streamBits(8'h08, 8'h07, 4, -1, 0);
    checkOutput("r31_zout", 32'(zout4), 32'd0);
    checkOutput("r31_eq",   32'(iguales4), 32'd0);
    idleCycles(2);

    // Gap of three invalid cycles after bit 1.
    doneCount4 = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    streamBits(8'h03, 8'h04, 4, 1, 3);
    checkOutput("r32_zout", 32'(zout4), 32'd1);
    checkOutput("r32_eq",   32'(iguales4), 32'd0);
    idleCycles(3);
    checkOutput("r32_dones", 32'(doneCount4), 32'd1);

    // Abort after two bits, then a full word.
    doneCount4 = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    streamBits(8'h03, 8'h00, 2, -1, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    streamBits(8'h0F, 8'h0E, 4, -1, 0);
    checkOutput("r33_zout", 32'(zout4), 32'd0);
    idleCycles(3);
    checkOutput("r33_dones", 32'(doneCount4), 32'd1);

    // Reset in the middle of a word.
    doneCount4 = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    streamBits(8'h05, 8'h02, 3, -1, 0);
    applyReset();
    idleCycles(6);
    checkOutput("r34_busy", 32'(busy4), 32'd0);
    checkOutput("r34_zout", 32'(zout4), 32'd0);
    checkOutput("r34_eq",   32'(iguales4), 32'd0);
    checkOutput("r34_dones", 32'(doneCount4), 32'd0);

    // N=8: new start accepted in the done cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    streamBits(8'hFF, 8'hFF, 8, -1, 0);
    checkOutput("r35_done1", 32'(done8), 32'd1);
    checkOutput("r35_zout1", 32'(zout8), 32'd1);
    checkOutput("r35_eq1",   32'(iguales8), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("r35_busy", 32'(busy8), 32'd1);
    streamBits(8'h00, 8'h01, 8, -1, 0);
    checkOutput("r35_done2", 32'(done8), 32'd1);
    checkOutput("r35_zout2", 32'(zout8), 32'd1);
    checkOutput("r35_eq2",   32'(iguales8), 32'd0);
    idleCycles(2);

    // Random traffic: aborts, gaps, stray bit_valid in IDLE, occasional reset.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 249) == 0)
        applyReset();
      else
        applyStimulus(1'($urandom_range(0, 13) == 0), 1'($urandom_range(0, 3) != 0),
                      1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
